mem_req_sched: RTL and testbench

MEM_REQ_SCHED -- requirements
Module: mem_req_sched

---
 rtl/mem_req_sched_pkg.sv | 21 ++
 rtl/mem_req_sched_tag_alloc.sv | 66 ++++++
 rtl/mem_req_sched.sv | 130 +++++++++++++
 tb/tb_mem_req_sched.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_sched_pkg.sv
// Shared types for the memory request scheduler: FSM state encoding and the
// request record steered from the winning requester into the memory register.
package mem_req_sched_pkg;

    localparam int DEF_PA_WIDTH   = 32;
    localparam int DEF_LINE_BYTES = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_STALL = 2'd2
    } sched_state_e;

    // Sized for the default line geometry; the top casts through it.
    typedef struct packed {
        logic [DEF_PA_WIDTH-1:0]     addr;
        logic [DEF_LINE_BYTES*8-1:0] data;
        logic                        write;
    } mem_req_t;

endpackage

// File: rtl/mem_req_sched_tag_alloc.sv
// Read-tag pool: busy vector, lowest-free encoder, alloc/free update, busy
// count and a sticky error for acks that name a tag that is not allocated.
module tag_alloc #(
    parameter int ID_WIDTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_i,
    input  logic                ack_i,
    input  logic [ID_WIDTH-1:0] ack_id_i,
    output logic                free_avail_o,
    output logic [ID_WIDTH-1:0] free_id_o,
    output logic [ID_WIDTH:0]   busy_cnt_o,
    output logic                err_o
);
    localparam int NUM_TAGS = 2 ** ID_WIDTH;

    logic [NUM_TAGS-1:0] busy_q, busy_d;
    logic                err_q, err_d;

    // Encoder looks only at busy_q, so a tag freed this cycle waits one cycle.
    always_comb begin
        free_avail_o = 1'b0;
        free_id_o    = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_avail_o = 1'b1;
                free_id_o    = ID_WIDTH'(i);
            end
        end
    end

    always_comb begin
        busy_cnt_o = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            busy_cnt_o = busy_cnt_o + {{ID_WIDTH{1'b0}}, busy_q[i]};
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        busy_d = busy_q;
        err_d  = err_q;
        if (ack_i) begin
            if (busy_q[ack_id_i]) busy_d[ack_id_i] = 1'b0;
            else                  err_d            = 1'b1;
        end
        if (alloc_i) busy_d[free_id_o] = 1'b1;
    end

    // NOTE: the busy vector is control state, not storage, so it is reset;
    // state registers use non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/mem_req_sched.sv
// Two-requester memory line scheduler with tagged reads. Define
// MEM_REQ_SCHED_STARVE_EN to add the instruction-side aging counter.
module mem_req_sched
    import mem_req_sched_pkg::*;
#(
    parameter int PA_WIDTH     = DEF_PA_WIDTH,
    parameter int LINE_BYTES   = DEF_LINE_BYTES,
    parameter int ID_WIDTH     = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_instr_req,
    input  logic [PA_WIDTH-1:0]     i_instr_addr,
    input  logic                    i_data_req,
    input  logic [PA_WIDTH-1:0]     i_data_addr,
    input  logic                    i_data_write,
    input  logic [LINE_BYTES*8-1:0] i_data_wdata,
    output logic                    o_instr_grant,
    output logic                    o_data_grant,
    output logic [ID_WIDTH-1:0]     o_grant_id,
    output logic                    o_mem_enable,
    output logic                    o_mem_write,
    output logic [PA_WIDTH-1:0]     o_mem_addr,
    output logic [LINE_BYTES*8-1:0] o_mem_data,
    output logic [ID_WIDTH-1:0]     o_mem_id,
    input  logic                    i_mem_full,
    input  logic                    i_mem_ack,
    input  logic [ID_WIDTH-1:0]     i_mem_ack_id,
    output logic [ID_WIDTH:0]       o_tags_busy,
    output logic                    o_err
);
    localparam int LINE_W = LINE_BYTES * 8;

    sched_state_e          state_q, state_d;
    logic                  free_avail;
    logic [ID_WIDTH-1:0]   free_id;
    logic                  instr_elig, data_elig, starve_win;
    logic                  grant_instr, grant_data, alloc;
    logic [ID_WIDTH-1:0]   grant_id;
    mem_req_t              req_sel;
    logic                  mem_write_q;
    logic [PA_WIDTH-1:0]   mem_addr_q;
    logic [LINE_W-1:0]     mem_data_q;
    logic [ID_WIDTH-1:0]   mem_id_q;

    tag_alloc #(.ID_WIDTH(ID_WIDTH)) u_tag_alloc (
        .clk          (clk),
        .rst          (rst),
        .alloc_i      (alloc),
        .ack_i        (i_mem_ack),
        .ack_id_i     (i_mem_ack_id),
        .free_avail_o (free_avail),
        .free_id_o    (free_id),
        .busy_cnt_o   (o_tags_busy),
        .err_o        (o_err)
    );

`ifdef MEM_REQ_SCHED_STARVE_EN
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;

    // Saturates at the limit so the instruction side keeps its claim until granted.
    assign starve_win = (wait_q == WAIT_W'(STARVE_LIMIT));

    always_comb begin
        wait_d = wait_q;
        if (grant_instr)                     wait_d = '0;
        else if (i_instr_req && !starve_win) wait_d = wait_q + WAIT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) wait_q <= '0;
        else     wait_q <= wait_d;
    end
`else
    assign starve_win = 1'b0;
`endif

    always_comb begin
        instr_elig  = !rst && i_instr_req && !i_mem_full && free_avail;
        data_elig   = !rst && i_data_req && !i_mem_full && (i_data_write || free_avail);
        grant_instr = instr_elig && (!data_elig || starve_win);
        grant_data  = data_elig && !grant_instr;
        alloc       = grant_instr || (grant_data && !i_data_write);
        grant_id    = alloc ? free_id : '0;

        state_d = ST_IDLE;
        if (grant_instr || grant_data)   state_d = ST_ISSUE;
        else if (i_instr_req || i_data_req) state_d = ST_STALL;

        req_sel = '0;
        if (grant_data) begin
            req_sel.addr  = DEF_PA_WIDTH'(i_data_addr);
            req_sel.data  = (DEF_LINE_BYTES * 8)'(i_data_wdata);
            req_sel.write = i_data_write;
        end else begin
            req_sel.addr  = DEF_PA_WIDTH'(i_instr_addr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_id_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == ST_ISSUE) begin
                mem_write_q <= req_sel.write;
                mem_addr_q  <= PA_WIDTH'(req_sel.addr);
                mem_data_q  <= LINE_W'(req_sel.data);
                mem_id_q    <= grant_id;
            end
        end
    end

    // ISSUE is entered exactly on a grant edge, so it doubles as the memory strobe.
    assign o_mem_enable  = (state_q == ST_ISSUE);
    assign o_mem_write   = mem_write_q;
    assign o_mem_addr    = mem_addr_q;
    assign o_mem_data    = mem_data_q;
    assign o_mem_id      = mem_id_q;
    assign o_instr_grant = grant_instr;
    assign o_data_grant  = grant_data;
    assign o_grant_id    = grant_id;

endmodule

// File: tb/tb_mem_req_sched.sv
// Directed bench for mem_req_sched; STARVE expectations follow MEM_REQ_SCHED_STARVE_EN.
module tb_mem_req_sched;
    import mem_req_sched_pkg::*;

    localparam int PA_WIDTH   = 32;
    localparam int LINE_BYTES = 16;
    localparam int ID_WIDTH   = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    i_instr_req;
    logic [PA_WIDTH-1:0]     i_instr_addr;
    logic                    i_data_req;
    logic [PA_WIDTH-1:0]     i_data_addr;
    logic                    i_data_write;
    logic [LINE_BYTES*8-1:0] i_data_wdata;
    logic                    o_instr_grant, o_data_grant;
    logic [ID_WIDTH-1:0]     o_grant_id;
    logic                    o_mem_enable, o_mem_write;
    logic [PA_WIDTH-1:0]     o_mem_addr;
    logic [LINE_BYTES*8-1:0] o_mem_data;
    logic [ID_WIDTH-1:0]     o_mem_id;
    logic                    i_mem_full, i_mem_ack;
    logic [ID_WIDTH-1:0]     i_mem_ack_id;
    logic [ID_WIDTH:0]       o_tags_busy;
    logic                    o_err;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] WDATA = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

    mem_req_sched #(.PA_WIDTH(PA_WIDTH), .LINE_BYTES(LINE_BYTES), .ID_WIDTH(ID_WIDTH),
                    .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_instr_req(i_instr_req), .i_instr_addr(i_instr_addr),
        .i_data_req(i_data_req), .i_data_addr(i_data_addr),
        .i_data_write(i_data_write), .i_data_wdata(i_data_wdata),
        .o_instr_grant(o_instr_grant), .o_data_grant(o_data_grant), .o_grant_id(o_grant_id),
        .o_mem_enable(o_mem_enable), .o_mem_write(o_mem_write), .o_mem_addr(o_mem_addr),
        .o_mem_data(o_mem_data), .o_mem_id(o_mem_id),
        .i_mem_full(i_mem_full), .i_mem_ack(i_mem_ack), .i_mem_ack_id(i_mem_ack_id),
        .o_tags_busy(o_tags_busy), .o_err(o_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_instr_req = 0; i_instr_addr = '0; i_data_req = 0; i_data_addr = '0;
        i_data_write = 0; i_data_wdata = '0; i_mem_full = 0; i_mem_ack = 0; i_mem_ack_id = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        i_instr_req = 1; i_data_req = 1; i_data_write = 1; i_mem_ack = 1; i_mem_ack_id = 2'd1;
        tick();
        tick();
        @(negedge clk);
        checks++; if (o_instr_grant !== 1'b0) begin failures++; $display("FAIL rst_instr_grant: got %0b want 0", o_instr_grant); end
        checks++; if (o_data_grant !== 1'b0) begin failures++; $display("FAIL rst_data_grant: got %0b want 0", o_data_grant); end
        checks++; if (o_mem_enable !== 1'b0) begin failures++; $display("FAIL rst_mem_enable: got %0b want 0", o_mem_enable); end
        checks++; if (o_mem_addr !== '0 || o_mem_id !== '0 || o_mem_write !== 1'b0) begin failures++; $display("FAIL rst_mem_regs: addr %h id %0d wr %0b want zeros", o_mem_addr, o_mem_id, o_mem_write); end
        checks++; if (o_tags_busy !== 3'd0) begin failures++; $display("FAIL rst_tags_busy: got %0d want 0", o_tags_busy); end
        checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL rst_err: got %0b want 0", o_err); end
        checks++; if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL rst_state: got %0d want IDLE", dut.state_q); end
        tick();
        rst = 1'b0;
        clear_inputs();
        tick();
        @(negedge clk);
        checks++; if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL idle_state: got %0d want IDLE", dut.state_q); end
        tick();
    endtask

    task automatic test_lone_read();
        do_reset();
        i_instr_req = 1; i_instr_addr = 32'h100;
        @(negedge clk);
        checks++; if (o_instr_grant !== 1'b1 || o_grant_id !== 2'd0) begin failures++; $display("FAIL lone_grant: got g=%0b id=%0d want g=1 id=0", o_instr_grant, o_grant_id); end
        checks++; if (o_data_grant !== 1'b0 || o_mem_enable !== 1'b0) begin failures++; $display("FAIL lone_grant_cycle: dgrant=%0b en=%0b want 0 0", o_data_grant, o_mem_enable); end
        tick();
        i_instr_req = 0;
        @(negedge clk);
        checks++; if (o_mem_enable !== 1'b1 || o_mem_addr !== 32'h100 || o_mem_id !== 2'd0 || o_mem_write !== 1'b0) begin failures++; $display("FAIL lone_issue: en=%0b addr=%h id=%0d wr=%0b want 1 100 0 0", o_mem_enable, o_mem_addr, o_mem_id, o_mem_write); end
        checks++; if (o_instr_grant !== 1'b0 || o_tags_busy !== 3'd1) begin failures++; $display("FAIL lone_after: grant=%0b busy=%0d want 0 1", o_instr_grant, o_tags_busy); end
        tick();
        i_mem_ack = 1; i_mem_ack_id = 2'd0;
        @(negedge clk);
        checks++; if (o_mem_enable !== 1'b0) begin failures++; $display("FAIL lone_single_pulse: en=%0b want 0", o_mem_enable); end
        tick();
        i_mem_ack = 0;
        @(negedge clk);
        checks++; if (o_tags_busy !== 3'd0 || o_err !== 1'b0) begin failures++; $display("FAIL lone_ack: busy=%0d err=%0b want 0 0", o_tags_busy, o_err); end
    endtask

    task automatic test_starve();
        do_reset();
        i_instr_req = 1; i_instr_addr = 32'h180;
        i_data_req = 1; i_data_write = 1; i_data_addr = 32'h400; i_data_wdata = WDATA;
`ifdef MEM_REQ_SCHED_STARVE_EN
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (o_data_grant !== 1'b1 || o_instr_grant !== 1'b0) begin failures++; $display("FAIL starve_data_c%0d: d=%0b i=%0b want 1 0", c, o_data_grant, o_instr_grant); end
            tick();
        end
        @(negedge clk);
        checks++; if (o_instr_grant !== 1'b1 || o_data_grant !== 1'b0) begin failures++; $display("FAIL starve_instr_win: i=%0b d=%0b want 1 0", o_instr_grant, o_data_grant); end
        tick();
`else
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++; if (o_data_grant !== 1'b1 || o_instr_grant !== 1'b0) begin failures++; $display("FAIL strict_prio_c%0d: d=%0b i=%0b want 1 0", c, o_data_grant, o_instr_grant); end
            tick();
        end
`endif
        clear_inputs();
    endtask

    task automatic test_tags_full();
        do_reset();
        i_instr_req = 1;
        for (int i = 0; i < 4; i++) begin
            i_instr_addr = 32'h200 + 32'(i * 16);
            @(negedge clk);
            checks++; if (o_instr_grant !== 1'b1 || o_grant_id !== ID_WIDTH'(i)) begin failures++; $display("FAIL tags_grant_%0d: g=%0b id=%0d want 1 %0d", i, o_instr_grant, o_grant_id, i); end
            tick();
        end
        i_instr_addr = 32'h240;
        @(negedge clk);
        checks++; if (o_instr_grant !== 1'b0 || o_tags_busy !== 3'd4) begin failures++; $display("FAIL tags_full: g=%0b busy=%0d want 0 4", o_instr_grant, o_tags_busy); end
        tick();
        i_mem_ack = 1; i_mem_ack_id = 2'd2;
        @(negedge clk);
        checks++; if (dut.state_q !== ST_STALL) begin failures++; $display("FAIL tags_stall_state: got %0d want STALL", dut.state_q); end
        checks++; if (o_instr_grant !== 1'b0) begin failures++; $display("FAIL tags_freed_same_cycle: g=%0b want 0", o_instr_grant); end
        tick();
        i_mem_ack = 0;
        @(negedge clk);
        checks++; if (o_instr_grant !== 1'b1 || o_grant_id !== 2'd2 || o_tags_busy !== 3'd3) begin failures++; $display("FAIL tags_regrant: g=%0b id=%0d busy=%0d want 1 2 3", o_instr_grant, o_grant_id, o_tags_busy); end
        tick();
        i_instr_req = 0;
        @(negedge clk);
        checks++; if (o_tags_busy !== 3'd4 || o_mem_addr !== 32'h240 || o_mem_id !== 2'd2) begin failures++; $display("FAIL tags_regrant_issue: busy=%0d addr=%h id=%0d want 4 240 2", o_tags_busy, o_mem_addr, o_mem_id); end
        tick();
    endtask

    task automatic test_write_when_full();
        do_reset();
        i_instr_req = 1;
        for (int i = 0; i < 4; i++) tick();
        i_instr_req = 0;
        i_data_req = 1; i_data_write = 1; i_data_addr = 32'h340; i_data_wdata = WDATA;
        @(negedge clk);
        checks++; if (o_data_grant !== 1'b1 || o_grant_id !== 2'd0 || o_tags_busy !== 3'd4) begin failures++; $display("FAIL wr_full_grant: d=%0b id=%0d busy=%0d want 1 0 4", o_data_grant, o_grant_id, o_tags_busy); end
        tick();
        i_data_req = 0; i_data_write = 0;
        @(negedge clk);
        checks++; if (o_mem_enable !== 1'b1 || o_mem_write !== 1'b1 || o_mem_id !== 2'd0 || o_mem_addr !== 32'h340) begin failures++; $display("FAIL wr_full_issue: en=%0b wr=%0b id=%0d addr=%h want 1 1 0 340", o_mem_enable, o_mem_write, o_mem_id, o_mem_addr); end
        checks++; if (o_mem_data !== WDATA || o_tags_busy !== 3'd4) begin failures++; $display("FAIL wr_full_data: data=%h busy=%0d want %h 4", o_mem_data, o_tags_busy, WDATA); end
        tick();
        i_mem_ack = 1; i_mem_ack_id = 2'd3;
        tick();
        i_mem_ack = 1; i_mem_ack_id = 2'd1; i_instr_req = 1; i_instr_addr = 32'h360;
        @(negedge clk);
        checks++; if (o_tags_busy !== 3'd3 || o_instr_grant !== 1'b1 || o_grant_id !== 2'd3) begin failures++; $display("FAIL net0_alloc: busy=%0d g=%0b id=%0d want 3 1 3", o_tags_busy, o_instr_grant, o_grant_id); end
        tick();
        i_mem_ack = 0; i_instr_addr = 32'h370;
        @(negedge clk);
        checks++; if (o_tags_busy !== 3'd3 || o_instr_grant !== 1'b1 || o_grant_id !== 2'd1) begin failures++; $display("FAIL net0_result: busy=%0d g=%0b id=%0d want 3 1 1", o_tags_busy, o_instr_grant, o_grant_id); end
        tick();
        i_instr_req = 0;
        @(negedge clk);
        checks++; if (o_tags_busy !== 3'd4) begin failures++; $display("FAIL net0_refill: busy=%0d want 4", o_tags_busy); end
        tick();
    endtask

    task automatic test_mem_full();
        do_reset();
        i_mem_full = 1;
        i_instr_req = 1; i_instr_addr = 32'h500;
        i_data_req = 1; i_data_write = 0; i_data_addr = 32'h600;
        @(negedge clk);
        checks++; if (o_instr_grant !== 1'b0 || o_data_grant !== 1'b0) begin failures++; $display("FAIL full_no_grant: i=%0b d=%0b want 0 0", o_instr_grant, o_data_grant); end
        tick();
        i_mem_full = 0;
        @(negedge clk);
        checks++; if (dut.state_q !== ST_STALL) begin failures++; $display("FAIL full_state: got %0d want STALL", dut.state_q); end
        checks++; if (o_data_grant !== 1'b1 || o_instr_grant !== 1'b0 || o_grant_id !== 2'd0) begin failures++; $display("FAIL full_release: d=%0b i=%0b id=%0d want 1 0 0", o_data_grant, o_instr_grant, o_grant_id); end
        tick();
        i_data_req = 0;
        @(negedge clk);
        checks++; if (o_instr_grant !== 1'b1 || o_grant_id !== 2'd1) begin failures++; $display("FAIL full_instr_next: g=%0b id=%0d want 1 1", o_instr_grant, o_grant_id); end
        checks++; if (o_mem_enable !== 1'b1 || o_mem_addr !== 32'h600 || o_mem_write !== 1'b0 || o_mem_id !== 2'd0) begin failures++; $display("FAIL full_data_issue: en=%0b addr=%h wr=%0b id=%0d want 1 600 0 0", o_mem_enable, o_mem_addr, o_mem_write, o_mem_id); end
        tick();
        clear_inputs();
    endtask

    task automatic test_err();
        do_reset();
        i_instr_req = 1; i_instr_addr = 32'h700;
        tick();
        i_instr_req = 0; i_mem_ack = 1; i_mem_ack_id = 2'd1;
        @(negedge clk);
        checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL err_before_edge: got %0b want 0", o_err); end
        tick();
        i_mem_ack = 0;
        @(negedge clk);
        checks++; if (o_err !== 1'b1 || o_tags_busy !== 3'd1) begin failures++; $display("FAIL err_free_ack: err=%0b busy=%0d want 1 1", o_err, o_tags_busy); end
        tick();
        tick();
        @(negedge clk);
        checks++; if (o_err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %0b want 1", o_err); end
        do_reset();
        @(negedge clk);
        checks++; if (o_err !== 1'b0 || o_tags_busy !== 3'd0) begin failures++; $display("FAIL err_reset_clear: err=%0b busy=%0d want 0 0", o_err, o_tags_busy); end
        tick();
        i_mem_ack = 1; i_mem_ack_id = 2'd0;
        tick();
        i_mem_ack = 0;
        @(negedge clk);
        checks++; if (o_err !== 1'b1 || o_tags_busy !== 3'd0) begin failures++; $display("FAIL err_after_reset_ack: err=%0b busy=%0d want 1 0", o_err, o_tags_busy); end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_lone_read();
        test_starve();
        test_tags_full();
        test_write_when_full();
        test_mem_full();
        test_err();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
